// File: rtl/video_window_place.sv
// video_window_place: composites a FIFO-buffered window stream onto the output raster; `VIDEO_WINDOW_INVERT_EN adds window inversion
module video_window_place #(
  parameter int CH = 3,
  parameter int DATA_W = 8,
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int CNT_W = 12,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                   pixclk_in,
  input  logic                   rst_n,
  input  logic                   vs_in,
  input  logic                   hs_in,
  input  logic                   de_in,
  input  logic                   win_valid,
  input  logic [CH*DATA_W-1:0]   win_data,
  output logic                   win_ready,
  input  logic [CNT_W-1:0]       dest_w,
  input  logic [CNT_W-1:0]       dest_h,
  input  logic [CNT_W-1:0]       off_x,
  input  logic [CNT_W-1:0]       off_y,
  input  logic [CH*DATA_W-1:0]   bg_color,
  input  logic                   invert,
  output logic                   vs_out,
  output logic                   hs_out,
  output logic                   de_out,
  output logic [CH*DATA_W-1:0]   data_out,
  output logic                   underflow,
  output logic [15:0]            underflow_cnt
);
  localparam int W = CH * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] H_LIM = (CNT_W+1)'(H_ACT);
  localparam logic [CNT_W:0] V_LIM = (CNT_W+1)'(V_ACT);
  typedef enum logic {WAIT_VS, RUN} state_t;
  state_t state;
  logic vs_d, de_d;
  logic [CNT_W-1:0] h_cnt, v_cnt, sw, sh, sx, sy;
  logic [W-1:0] sbg, head, pix;
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CNT_W:0] x_end, y_end;
  logic vs_rise, empty, full, popwin, inwin, pop, push;
  assign vs_rise = vs_in && !vs_d;
  assign x_end = {1'b0, sx} + {1'b0, sw};
  assign y_end = {1'b0, sy} + {1'b0, sh};
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  // popwin ignores raster clipping so off-screen window pixels still drain the FIFO
  assign popwin = state == RUN && de_in && h_cnt >= sx && {1'b0, h_cnt} < x_end &&
                  v_cnt >= sy && {1'b0, v_cnt} < y_end;
  assign inwin = popwin && {1'b0, h_cnt} < H_LIM && {1'b0, v_cnt} < V_LIM;
  assign pop = popwin && !empty;
  assign win_ready = !full || pop;
  assign push = win_valid && win_ready && !vs_rise;
  assign head = mem[rd_ptr[AW-1:0]];
`ifdef VIDEO_WINDOW_INVERT_EN
  logic sinv;
  assign pix = head ^ {W{sinv}};
`else
  logic unused_invert;
  assign unused_invert = invert;
  assign pix = head;
`endif
  always_ff @(posedge pixclk_in)
    if (push) mem[wr_ptr[AW-1:0]] <= win_data;
  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_VS;
      vs_d <= 1'b0;
      de_d <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      sw <= '0;
      sh <= '0;
      sx <= '0;
      sy <= '0;
      sbg <= '0;
`ifdef VIDEO_WINDOW_INVERT_EN
      sinv <= 1'b0;
`endif
      wr_ptr <= '0;
      rd_ptr <= '0;
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
      data_out <= '0;
      underflow <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      vs_d <= vs_in;
      de_d <= de_in;
      vs_out <= vs_in;
      hs_out <= hs_in;
      de_out <= de_in;
      h_cnt <= de_in ? (&h_cnt ? h_cnt : h_cnt + 1'b1) : '0;
      if (vs_rise) begin
        state <= RUN;
        sw <= dest_w;
        sh <= dest_h;
        sx <= off_x;
        sy <= off_y;
        sbg <= bg_color;
`ifdef VIDEO_WINDOW_INVERT_EN
        sinv <= invert;
`endif
        wr_ptr <= '0;
        rd_ptr <= '0;
        v_cnt <= '0;
      end else begin
        if (de_d && !de_in && !(&v_cnt)) v_cnt <= v_cnt + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
      data_out <= (state == RUN && de_in) ? ((inwin && !empty) ? pix : sbg) : '0;
      if (inwin && empty) begin
        underflow <= 1'b1;
        if (!(&underflow_cnt)) underflow_cnt <= underflow_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_window_place.sv
// tb_video_window_place: directed compositing, underflow, clipping, frame-latch, backpressure, invert and reset checks
module tb_video_window_place;
  localparam int DEPTH = 8;
  localparam logic [23:0] BG = 24'h102030;
`ifdef VIDEO_WINDOW_INVERT_EN
  localparam logic [23:0] INV_EXP = 24'hF0FF00;
`else
  localparam logic [23:0] INV_EXP = 24'h0F00FF;
`endif
  logic pixclk_in = 0, rst_n = 1, vs_in = 0, hs_in = 0, de_in = 0, win_valid = 0, invert = 0;
  logic [23:0] win_data = 0, bg_color = 0;
  logic [11:0] dest_w = 0, dest_h = 0, off_x = 0, off_y = 0;
  logic win_ready, vs_out, hs_out, de_out, underflow;
  logic [23:0] data_out;
  logic [15:0] underflow_cnt;
  int errors = 0, checks = 0;
  logic [23:0] q[$];
  bit run = 0, pvs = 0, pde = 0, sinv = 0, stream = 0;
  int mh = 0, my = 0, ucnt = 0, sx = 0, sy = 0, sw = 0, sh = 0;
  logic [23:0] sbg = 0, nxt = 0;
  logic [23:0] cap [8][32];

  video_window_place #(.CH(3), .DATA_W(8), .H_ACT(16), .V_ACT(8), .CNT_W(12), .FIFO_DEPTH(DEPTH)) dut (
    .pixclk_in(pixclk_in), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .dest_w(dest_w), .dest_h(dest_h), .off_x(off_x), .off_y(off_y),
    .bg_color(bg_color), .invert(invert), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .data_out(data_out), .underflow(underflow), .underflow_cnt(underflow_cnt));

  always #5 pixclk_in = ~pixclk_in;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(bit vs, bit hs, bit de);
    logic [23:0] exp;
    bit pop, vis, pw, rise, rdy, acc;
    int cx, cy;
    vs_in = vs; hs_in = hs; de_in = de; win_data = nxt;
    rise = vs && !pvs;
    pop = 0; vis = 0; exp = 0;
    if (run && de) begin
      pw = mh >= sx && mh < sx + sw && my >= sy && my < sy + sh;
      vis = pw && mh < 16 && my < 8;
      pop = pw && q.size() > 0;
      exp = sbg;
      if (vis && pop) exp = sinv ? ~q[0] : q[0];
      if (vis && !pop && ucnt < 65535) ucnt++;
    end
    rdy = q.size() < DEPTH || pop;
    #3;
    check("win_ready", win_ready, rdy);
    acc = win_valid && rdy;
    @(posedge pixclk_in);
    if (rise) begin
      q.delete();
      sx = off_x; sy = off_y; sw = dest_w; sh = dest_h; sbg = bg_color;
`ifdef VIDEO_WINDOW_INVERT_EN
      sinv = invert;
`endif
      run = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(win_data);
    end
    if (acc) nxt++;
    cx = mh; cy = my;
    if (rise) my = 0;
    else if (pde && !de) my++;
    mh = de ? mh + 1 : 0;
    pvs = vs; pde = de;
    #1;
    check("vs_out", vs_out, vs);
    check("hs_out", hs_out, hs);
    check("de_out", de_out, de);
    check("data_out", data_out, exp);
    if (de && cy < 8 && cx < 32) cap[cy][cx] = data_out;
  endtask

  task automatic mid_reset();
    #1 rst_n = 0;
    #1;
    check("rst_vs", vs_out, 0);
    check("rst_de", de_out, 0);
    check("rst_data", data_out, 0);
    check("rst_uf", underflow, 0);
    check("rst_ucnt", underflow_cnt, 0);
    check("rst_ready", win_ready, 1);
    q.delete(); run = 0; pvs = 0; pde = 0; mh = 0; my = 0; ucnt = 0; sinv = 0;
    #1 rst_n = 1;
  endtask

  task automatic vsync(int npre);
    win_valid = 0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    win_valid = npre > 0;
    repeat (npre) cyc(0, 0, 0);
    win_valid = stream;
  endtask

  task automatic line(int dlen, int rst_at);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < dlen; i++) begin
      if (i == rst_at) mid_reset();
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic frame(int npre);
    vsync(npre);
    for (int l = 0; l < 8; l++) line(20, -1);
  endtask

  initial begin
    #2 rst_n = 0;
    repeat (2) @(posedge pixclk_in);
    #1;
    check("reset_vs", vs_out, 0);
    check("reset_hs", hs_out, 0);
    check("reset_de", de_out, 0);
    check("reset_data", data_out, 0);
    check("reset_uf", underflow, 0);
    check("reset_ucnt", underflow_cnt, 0);
    check("reset_ready", win_ready, 1);
    rst_n = 1;
    dest_w = 4; dest_h = 2; off_x = 3; off_y = 2; bg_color = BG;
    // basic placement, FIFO pre-filled with the whole window
    nxt = 24'hA0A0A0;
    frame(8);
    check("t1_2_3", cap[2][3], 24'hA0A0A0);
    check("t1_2_6", cap[2][6], 24'hA0A0A3);
    check("t1_3_3", cap[3][3], 24'hA0A0A4);
    check("t1_3_6", cap[3][6], 24'hA0A0A7);
    check("t1_2_2", cap[2][2], BG);
    check("t1_2_7", cap[2][7], BG);
    check("t1_4_3", cap[4][3], BG);
    check("t1_ucnt", underflow_cnt, 0);
    // only five window pixels available
    nxt = 24'hA0A0A0;
    frame(5);
    check("t2_3_3", cap[3][3], 24'hA0A0A4);
    check("t2_3_4", cap[3][4], BG);
    check("t2_3_6", cap[3][6], BG);
    check("t2_uf", underflow, 1);
    check("t2_ucnt", underflow_cnt, 3);
    // window clipped at the right raster edge
    off_x = 14; nxt = 24'hA0A0A0;
    frame(8);
    check("t3_2_14", cap[2][14], 24'hA0A0A0);
    check("t3_2_15", cap[2][15], 24'hA0A0A1);
    check("t3_2_16", cap[2][16], BG);
    check("t3_3_14", cap[3][14], 24'hA0A0A4);
    check("t3_3_15", cap[3][15], 24'hA0A0A5);
    check("t3_ucnt", underflow_cnt, 3);
    // mid-frame offset change, stale pixels flushed at vsync
    off_x = 3; nxt = 24'hA0A0A0;
    vsync(8);
    line(20, -1);
    off_x = 8;
    for (int l = 1; l < 8; l++) line(20, -1);
    check("t4a_2_3", cap[2][3], 24'hA0A0A0);
    check("t4a_2_8", cap[2][8], BG);
    nxt = 24'hDEAD00; win_valid = 1;
    repeat (3) cyc(0, 0, 0);
    win_valid = 0; nxt = 24'hA0A0A0;
    frame(8);
    check("t4b_2_8", cap[2][8], 24'hA0A0A0);
    check("t4b_3_11", cap[3][11], 24'hA0A0A7);
    check("t4b_2_3", cap[2][3], BG);
    check("t4_ucnt", underflow_cnt, 3);
    // backpressure with win_valid held high
    off_x = 3; nxt = 24'hA0A0A0; stream = 1;
    vsync(10);
    check("t5_full", win_ready, 0);
    for (int l = 0; l < 8; l++) line(20, -1);
    check("t5_2_3", cap[2][3], 24'hA0A0A0);
    check("t5_3_6", cap[3][6], 24'hA0A0A7);
    check("t5_full_end", win_ready, 0);
    check("t5_ucnt", underflow_cnt, 3);
    stream = 0; win_valid = 0;
    // inversion, then reset in the middle of a line
    invert = 1; nxt = 24'h0F00FF;
    frame(1);
    check("t6_2_3", cap[2][3], INV_EXP);
    check("t6_2_4", cap[2][4], BG);
    check("t6_2_2", cap[2][2], BG);
    check("t6_ucnt", underflow_cnt, 10);
    vsync(0);
    line(20, -1);
    line(20, -1);
    line(20, 5);
    for (int l = 3; l < 8; l++) line(20, -1);
    check("t6r_0_3", cap[0][3], 0);
    check("t6r_3_3", cap[3][3], 0);
    check("t6r_ucnt", underflow_cnt, 0);
    nxt = 24'h0F00FF;
    frame(1);
    check("t6b_2_3", cap[2][3], INV_EXP);
    check("t6b_3_3", cap[3][3], BG);
    check("t6b_uf", underflow, 1);
    check("t6b_ucnt", underflow_cnt, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
